// File: rtl/line_buffer_3x3_regs.sv
// 3x3 sliding-window generator for a WIDTH x WIDTH raster built from register line buffers.
// Optional macro LB_WIN_GATE_EN forces the window taps to zero while o_valid is low.
module line_buffer_3x3_regs #(
  parameter int BITW  = 8,
  parameter int WIDTH = 28
) (
  input  logic            i_CLK,
  input  logic            i_reset,
  input  logic            i_valid,
  input  logic [BITW-1:0] i_pixel,
  output logic            o_valid,
  output logic [BITW-1:0] o_win00,
  output logic [BITW-1:0] o_win01,
  output logic [BITW-1:0] o_win02,
  output logic [BITW-1:0] o_win10,
  output logic [BITW-1:0] o_win11,
  output logic [BITW-1:0] o_win12,
  output logic [BITW-1:0] o_win20,
  output logic [BITW-1:0] o_win21,
  output logic [BITW-1:0] o_win22,
  output logic [15:0]     row_count,
  output logic [15:0]     col_count
);

  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [15:0]     col_reg;
  logic [15:0]     row_reg;
  logic [15:0]     col_next;
  logic [15:0]     row_next;
  logic            valid_reg;
  logic            valid_next;
  logic [AW-1:0]   col_idx;
  logic            last_col;
  logic            last_row;
  logic [BITW-1:0] lb0_rd [WIDTH];
  logic [BITW-1:0] lb1_rd [WIDTH];
  logic [BITW-1:0] lb0_tap;
  logic [BITW-1:0] lb1_tap;
  logic [BITW-1:0] win_reg [3][3];

  assign col_idx  = col_reg[AW-1:0];
  assign last_col = (col_reg == 16'(WIDTH - 1));
  assign last_row = (row_reg == 16'(WIDTH - 1));
  assign lb0_tap  = lb0_rd[col_idx];
  assign lb1_tap  = lb1_rd[col_idx];

  // Each column owns one cell of each line; only the cell under the current column moves.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lb
      logic [BITW-1:0] lb0_cell_reg;
      logic [BITW-1:0] lb1_cell_reg;

      always_ff @(posedge i_CLK) begin
        if (i_reset) begin
          lb0_cell_reg <= '0;
          lb1_cell_reg <= '0;
        end else if (i_valid && (col_reg == 16'(gi))) begin
          lb0_cell_reg <= lb1_cell_reg;
          lb1_cell_reg <= i_pixel;
        end
      end

      assign lb0_rd[gi] = lb0_cell_reg;
      assign lb1_rd[gi] = lb1_cell_reg;
    end
  endgenerate

  always_comb begin
    col_next   = col_reg + 16'd1;
    row_next   = row_reg;
    valid_next = (row_reg >= 16'd2) && (col_reg >= 16'd2);
    if (last_col) begin
      col_next = '0;
      row_next = last_row ? 16'd0 : row_reg + 16'd1;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      col_reg   <= '0;
      row_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (i_valid) begin
      col_reg   <= col_next;
      row_reg   <= row_next;
      valid_reg <= valid_next;
    end
  end

  // Window rows: 0 is two rows up, 2 is the current row; column 2 is the newest.
  generate
    for (gi = 0; gi < 3; gi++) begin : g_win
      logic [BITW-1:0] new_tap;

      if (gi == 0) begin : g_top
        assign new_tap = lb0_tap;
      end else if (gi == 1) begin : g_mid
        assign new_tap = lb1_tap;
      end else begin : g_cur
        assign new_tap = i_pixel;
      end

      always_ff @(posedge i_CLK) begin
        if (i_reset) begin
          win_reg[gi][0] <= '0;
          win_reg[gi][1] <= '0;
          win_reg[gi][2] <= '0;
        end else if (i_valid) begin
          win_reg[gi][0] <= win_reg[gi][1];
          win_reg[gi][1] <= win_reg[gi][2];
          win_reg[gi][2] <= new_tap;
        end
      end
    end
  endgenerate

  assign o_valid   = valid_reg;
  assign row_count = row_reg;
  assign col_count = col_reg;

`ifdef LB_WIN_GATE_EN
  assign o_win00 = valid_reg ? win_reg[0][0] : '0;
  assign o_win01 = valid_reg ? win_reg[0][1] : '0;
  assign o_win02 = valid_reg ? win_reg[0][2] : '0;
  assign o_win10 = valid_reg ? win_reg[1][0] : '0;
  assign o_win11 = valid_reg ? win_reg[1][1] : '0;
  assign o_win12 = valid_reg ? win_reg[1][2] : '0;
  assign o_win20 = valid_reg ? win_reg[2][0] : '0;
  assign o_win21 = valid_reg ? win_reg[2][1] : '0;
  assign o_win22 = valid_reg ? win_reg[2][2] : '0;
`else
  assign o_win00 = win_reg[0][0];
  assign o_win01 = win_reg[0][1];
  assign o_win02 = win_reg[0][2];
  assign o_win10 = win_reg[1][0];
  assign o_win11 = win_reg[1][1];
  assign o_win12 = win_reg[1][2];
  assign o_win20 = win_reg[2][0];
  assign o_win21 = win_reg[2][1];
  assign o_win22 = win_reg[2][2];
`endif

endmodule

// File: tb/tb_line_buffer_3x3_regs.sv
// Scoreboard bench for line_buffer_3x3_regs on a 4x4 image; honours LB_WIN_GATE_EN when defined.
module tb_line_buffer_3x3_regs;

  localparam int BITW  = 8;
  localparam int WIDTH = 4;

  typedef struct packed {
    logic [8:0][BITW-1:0] win;
    logic                 valid;
    logic [15:0]          row;
    logic [15:0]          col;
  } exp_t;

  logic            clk;
  logic            i_reset;
  logic            i_valid;
  logic [BITW-1:0] i_pixel;
  logic            o_valid;
  logic [BITW-1:0] o_win00, o_win01, o_win02;
  logic [BITW-1:0] o_win10, o_win11, o_win12;
  logic [BITW-1:0] o_win20, o_win21, o_win22;
  logic [15:0]     row_count;
  logic [15:0]     col_count;
  logic [8:0][BITW-1:0] obs_win;

  int   compared;
  int   mismatched;
  int   hist[$];
  int   m_row;
  int   m_col;
  int   frame_valid;
  int   first_valid;
  exp_t exp_q[$];
  exp_t last_e;

  line_buffer_3x3_regs #(.BITW(BITW), .WIDTH(WIDTH)) dut (
    .i_CLK(clk), .i_reset(i_reset), .i_valid(i_valid), .i_pixel(i_pixel),
    .o_valid(o_valid),
    .o_win00(o_win00), .o_win01(o_win01), .o_win02(o_win02),
    .o_win10(o_win10), .o_win11(o_win11), .o_win12(o_win12),
    .o_win20(o_win20), .o_win21(o_win21), .o_win22(o_win22),
    .row_count(row_count), .col_count(col_count)
  );

  assign obs_win = {o_win22, o_win21, o_win20, o_win12, o_win11, o_win10,
                    o_win02, o_win01, o_win00};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] req);
    compared++;
    if (obs !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, req);
    end
  endtask

  task automatic check_outputs(input string pfx, input exp_t e);
    for (int k = 0; k < 9; k++)
      check_val($sformatf("%s win%0d%0d", pfx, k / 3, k % 3), 32'(obs_win[k]), 32'(e.win[k]));
    check_val({pfx, " o_valid"}, 32'(o_valid), 32'(e.valid));
    check_val({pfx, " row_count"}, 32'(row_count), 32'(e.row));
    check_val({pfx, " col_count"}, 32'(col_count), 32'(e.col));
  endtask

  // Reference: tap (R,C) after stream pixel n is stream pixel n-(2-R)*WIDTH-(2-C) since reset.
  function automatic exp_t model_accept(input int pix);
    exp_t e;
    int   n;
    int   k;
    n = hist.size();
    hist.push_back(pix);
    e.valid = (m_row >= 2) && (m_col >= 2);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        k = n - (2 - r) * WIDTH - (2 - c);
        e.win[r * 3 + c] = (k >= 0) ? BITW'(hist[k]) : '0;
`ifdef LB_WIN_GATE_EN
        if (!e.valid) e.win[r * 3 + c] = '0;
`endif
      end
    end
    if (m_col == WIDTH - 1) begin
      m_col = 0;
      m_row = (m_row == WIDTH - 1) ? 0 : m_row + 1;
    end else begin
      m_col = m_col + 1;
    end
    e.row = 16'(m_row);
    e.col = 16'(m_col);
    return e;
  endfunction

  task automatic send_pix(input int pix, input int gap);
    exp_t e;
    @(negedge clk);
    i_valid = 1'b1;
    i_pixel = BITW'(pix);
    exp_q.push_back(model_accept(pix));
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    if (exp_q.size() == 0) begin
      check_val("scoreboard empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_outputs($sformatf("px%0d", pix), e);
      last_e = e;
      if (e.valid) begin
        if (frame_valid == 0) first_valid = hist.size() % (WIDTH * WIDTH);
        frame_valid++;
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      check_outputs($sformatf("hold px%0d", pix), last_e);
    end
    $display("accept px=%0d gap=%0d valid=%0d row=%0d col=%0d", pix, gap, o_valid,
             row_count, col_count);
  endtask

  task automatic do_reset();
    exp_t z;
    @(negedge clk);
    i_reset = 1'b1;
    i_valid = 1'b1;
    i_pixel = 8'd99;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
    i_valid = 1'b0;
    hist.delete();
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    z = '0;
    last_e = z;
    check_outputs("reset", z);
    $display("reset applied");
  endtask

  task automatic run_frame(input int base, input int maxgap);
    int gap;
    logic [8:0][BITW-1:0] first_win;
    frame_valid = 0;
    first_valid = -1;
    for (int i = 1; i <= WIDTH * WIDTH; i++) begin
      gap = (maxgap == 0) ? 0 : int'($urandom_range(1, maxgap));
      send_pix(base + i, gap);
      if (i == 11) begin
        first_win = {BITW'(base + 11), BITW'(base + 10), BITW'(base + 9),
                     BITW'(base + 7), BITW'(base + 6), BITW'(base + 5),
                     BITW'(base + 3), BITW'(base + 2), BITW'(base + 1)};
        for (int k = 0; k < 9; k++)
          check_val($sformatf("first window tap%0d", k), 32'(obs_win[k]), 32'(first_win[k]));
        check_val("first window valid", 32'(o_valid), 32'd1);
      end
    end
    check_val("valid windows per frame", 32'(frame_valid), 32'd4);
    check_val("first valid pixel index", 32'(first_valid), 32'd11);
    check_val("frame wrap row", 32'(row_count), 32'd0);
    check_val("frame wrap col", 32'(col_count), 32'd0);
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    i_reset     = 1'b0;
    i_valid     = 1'b0;
    i_pixel     = '0;
    m_row       = 0;
    m_col       = 0;
    frame_valid = 0;
    first_valid = -1;
    last_e      = '0;

    do_reset();
    run_frame(0, 0);
    run_frame(100, 0);

    do_reset();
    run_frame(0, 3);

    do_reset();
    for (int i = 1; i <= 7; i++) send_pix(i, 0);
    do_reset();
    run_frame(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
